// File: rtl/scaler_tap_acc_if.sv
// Product input and scaled-pixel output bundle between the dual-product DSP
// stage, the tap accumulator and the output formatter.
interface scaler_tap_acc_if #(
  parameter int OUT_W = 8
);
  logic                din_en;
  logic signed [15:0]  din_ab;
  logic signed [15:0]  din_db;
  logic                din_first;
  logic                din_last;
  logic                dout_en;
  logic [OUT_W-1:0]    dout_a;
  logic [OUT_W-1:0]    dout_d;
  logic                err_tap;

  modport master (
    output din_en, din_ab, din_db, din_first, din_last,
    input  dout_en, dout_a, dout_d, err_tap
  );

  modport slave (
    input  din_en, din_ab, din_db, din_first, din_last,
    output dout_en, dout_a, dout_d, err_tap
  );
endinterface

// File: rtl/scaler_tap_acc.sv
// Two-lane tap accumulator: sums a filter group of signed products per lane,
// then rounds, drops the coefficient fraction bits and clamps to an unsigned pixel.
module scaler_tap_acc #(
  parameter int TAPS_MAX  = 8,
  parameter int ACC_W     = 20,
  parameter int FRAC_BITS = 6,
  parameter int OUT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  scaler_tap_acc_if.slave  bus
);

  localparam int CNT_W = $clog2(TAPS_MAX + 1);
  localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(2 ** (FRAC_BITS - 1));
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2 ** OUT_W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_a_q, acc_a_d;
  logic signed [ACC_W-1:0]  acc_d_q, acc_d_d;
  logic [CNT_W-1:0]         tap_cnt_q, tap_cnt_d;
  logic                     s1_vld_q, s1_vld_d;
  logic signed [ACC_W-1:0]  s1_a_q, s1_a_d;
  logic signed [ACC_W-1:0]  s1_d_q, s1_d_d;
  logic                     dout_en_q, dout_en_d;
  logic [OUT_W-1:0]         dout_a_q, dout_a_d;
  logic [OUT_W-1:0]         dout_d_q, dout_d_d;
  logic                     err_q, err_d;

  logic signed [ACC_W-1:0]  ext_a_s, ext_d_s;
  logic signed [ACC_W-1:0]  sum_a_s, sum_d_s;

  // Round half up, arithmetic shift, then clamp into [0, 2^OUT_W-1].
  function automatic logic [OUT_W-1:0] sat_px(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W:0] r;
    r = $signed({sum[ACC_W-1], sum}) + HALF;
    r = r >>> FRAC_BITS;
    if (r[ACC_W]) begin
      sat_px = {OUT_W{1'b0}};
    end else if (r > SAT_MAX) begin
      sat_px = {OUT_W{1'b1}};
    end else begin
      sat_px = r[OUT_W-1:0];
    end
  endfunction

  assign ext_a_s = {{(ACC_W-16){bus.din_ab[15]}}, bus.din_ab};
  assign ext_d_s = {{(ACC_W-16){bus.din_db[15]}}, bus.din_db};
  assign sum_a_s = acc_a_q + ext_a_s;
  assign sum_d_s = acc_d_q + ext_d_s;

  // Group control, accumulation and stage-1 capture of the finished sum.
  always_comb begin
    state_d   = state_q;
    acc_a_d   = acc_a_q;
    acc_d_d   = acc_d_q;
    tap_cnt_d = tap_cnt_q;
    s1_vld_d  = 1'b0;
    s1_a_d    = s1_a_q;
    s1_d_d    = s1_d_q;
    err_d     = 1'b0;
    if (bus.din_en) begin
      if (bus.din_first) begin
        // A first tap always opens a fresh group; arriving mid-group drops the old one.
        err_d = (state_q == ACC);
        if (bus.din_last) begin
          s1_vld_d  = 1'b1;
          s1_a_d    = ext_a_s;
          s1_d_d    = ext_d_s;
          tap_cnt_d = {CNT_W{1'b0}};
          state_d   = IDLE;
        end else begin
          acc_a_d   = ext_a_s;
          acc_d_d   = ext_d_s;
          tap_cnt_d = CNT_W'(1);
          state_d   = ACC;
        end
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else if (tap_cnt_q >= CNT_W'(TAPS_MAX)) begin
        err_d     = 1'b1;
        tap_cnt_d = {CNT_W{1'b0}};
        state_d   = IDLE;
      end else if (bus.din_last) begin
        s1_vld_d  = 1'b1;
        s1_a_d    = sum_a_s;
        s1_d_d    = sum_d_s;
        tap_cnt_d = {CNT_W{1'b0}};
        state_d   = IDLE;
      end else begin
        acc_a_d   = sum_a_s;
        acc_d_d   = sum_d_s;
        tap_cnt_d = tap_cnt_q + CNT_W'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // Stage 2: scale and saturate; pixels hold their value between pulses.
  always_comb begin
    dout_en_d = s1_vld_q;
    dout_a_d  = dout_a_q;
    dout_d_d  = dout_d_q;
    if (s1_vld_q) begin
      dout_a_d = sat_px(s1_a_q);
      dout_d_d = sat_px(s1_d_q);
    end else begin
      dout_a_d = dout_a_q;
      dout_d_d = dout_d_q;
    end
  end

  // All state, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_a_q   <= '0;
      acc_d_q   <= '0;
      tap_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_d_q    <= '0;
      dout_en_q <= 1'b0;
      dout_a_q  <= '0;
      dout_d_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_a_q   <= acc_a_d;
      acc_d_q   <= acc_d_d;
      tap_cnt_q <= tap_cnt_d;
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_d_q    <= s1_d_d;
      dout_en_q <= dout_en_d;
      dout_a_q  <= dout_a_d;
      dout_d_q  <= dout_d_d;
      err_q     <= err_d;
    end
  end

  assign bus.dout_en = dout_en_q;
  assign bus.dout_a  = dout_a_q;
  assign bus.dout_d  = dout_d_q;
  assign bus.err_tap = err_q;

endmodule

// File: tb/tb_scaler_tap_acc.sv
// Directed bench for scaler_tap_acc: the driver queues hand-computed results and
// their arrival cycle; a negedge monitor pops and compares whenever the DUT pulses.
module tb_scaler_tap_acc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scaler_tap_acc_if #(.OUT_W(8)) bus ();

  scaler_tap_acc #(
    .TAPS_MAX (8),
    .ACC_W    (20),
    .FRAC_BITS(6),
    .OUT_W    (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int         q_cyc[$];
  logic [7:0] q_a[$];
  logic [7:0] q_d[$];
  string      q_name[$];
  int         q_err[$];

  // Monitor: every dout_en / err_tap pulse must match the head of its queue.
  always @(negedge clk) begin
    string      nm;
    int         ec;
    logic [7:0] ea, ed;
    if (bus.dout_en === 1'b1) begin
      n_cmp++;
      if (q_a.size() == 0) begin
        n_bad++;
        $display("FAIL dout_unexpected: got dout_en=1 a=%0d d=%0d at cyc %0d, required no output",
                 bus.dout_a, bus.dout_d, cyc);
      end else begin
        nm = q_name.pop_front();
        ec = q_cyc.pop_front();
        ea = q_a.pop_front();
        ed = q_d.pop_front();
        if (bus.dout_a !== ea || bus.dout_d !== ed || cyc != ec) begin
          n_bad++;
          $display("FAIL %s: got a=%0d d=%0d cyc=%0d, required a=%0d d=%0d cyc=%0d",
                   nm, bus.dout_a, bus.dout_d, cyc, ea, ed, ec);
        end
      end
    end
    if (bus.err_tap === 1'b1) begin
      n_cmp++;
      if (q_err.size() == 0) begin
        n_bad++;
        $display("FAIL err_unexpected: got err_tap=1 at cyc %0d, required 0", cyc);
      end else begin
        ec = q_err.pop_front();
        if (cyc != ec) begin
          n_bad++;
          $display("FAIL err_timing: got err_tap at cyc %0d, required cyc %0d", cyc, ec);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_dout_en"}, int'(bus.dout_en), 0);
    chk({nm, "_dout_a"},  int'(bus.dout_a),  0);
    chk({nm, "_dout_d"},  int'(bus.dout_d),  0);
    chk({nm, "_err_tap"}, int'(bus.err_tap), 0);
  endtask

  // Drive one tap for one cycle and queue whatever it is expected to produce.
  task automatic tap(input logic f, input logic l, input int a, input int d,
                     input logic e_err, input logic e_out, input int ea, input int ed,
                     input string nm);
    bus.din_en    = 1'b1;
    bus.din_first = f;
    bus.din_last  = l;
    bus.din_ab    = 16'(a);
    bus.din_db    = 16'(d);
    if (e_err) q_err.push_back(cyc + 1);
    if (e_out) begin
      q_cyc.push_back(cyc + 2);
      q_a.push_back(8'(ea));
      q_d.push_back(8'(ed));
      q_name.push_back(nm);
    end
    @(negedge clk);
    bus.din_en    = 1'b0;
    bus.din_first = 1'b0;
    bus.din_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.din_en    = 1'b0;
    bus.din_first = 1'b0;
    bus.din_last  = 1'b0;
    bus.din_ab    = 16'sd0;
    bus.din_db    = 16'sd0;
    idle(2);
    chk_idle_outputs("reset");
    rst = 1'b0;
    idle(1);

    // 4-tap unity group: 4 x 1600 = 6400 -> 100
    tap(1'b1, 1'b0, 1600, 1600, 1'b0, 1'b0, 0, 0, "");
    tap(1'b0, 1'b0, 1600, 1600, 1'b0, 1'b0, 0, 0, "");
    tap(1'b0, 1'b0, 1600, 1600, 1'b0, 1'b0, 0, 0, "");
    tap(1'b0, 1'b1, 1600, 1600, 1'b0, 1'b1, 100, 100, "sum4");
    idle(3);

    // Rounding on single-tap groups; negative lane clamps to 0
    tap(1'b1, 1'b1, 95, -33, 1'b0, 1'b1, 1, 0, "round95");
    tap(1'b1, 1'b1, 96, -33, 1'b0, 1'b1, 2, 0, "round96");
    idle(3);

    // Saturation high and low
    tap(1'b1, 1'b0, 10000, 10000, 1'b0, 1'b0, 0, 0, "");
    tap(1'b0, 1'b1, 10000, 10000, 1'b0, 1'b1, 255, 255, "sat_hi");
    tap(1'b1, 1'b0, -20000, -20000, 1'b0, 1'b0, 0, 0, "");
    tap(1'b0, 1'b1, -20000, -20000, 1'b0, 1'b1, 0, 0, "sat_lo");
    idle(3);

    // Tap without first while idle
    tap(1'b0, 1'b0, 500, 500, 1'b1, 1'b0, 0, 0, "");
    idle(2);

    // Nine taps with no last: ninth overflows and aborts the group
    tap(1'b1, 1'b0, 100, 100, 1'b0, 1'b0, 0, 0, "");
    for (int i = 0; i < 7; i++) tap(1'b0, 1'b0, 100, 100, 1'b0, 1'b0, 0, 0, "");
    tap(1'b0, 1'b0, 100, 100, 1'b1, 1'b0, 0, 0, "");
    idle(2);
    tap(1'b1, 1'b0, 640, 640, 1'b0, 1'b0, 0, 0, "");
    tap(1'b0, 1'b1, 640, 640, 1'b0, 1'b1, 20, 20, "after_ovf");
    idle(3);

    // Exactly TAPS_MAX taps is legal: 8 x 80 = 640 -> 10
    tap(1'b1, 1'b0, 80, 80, 1'b0, 1'b0, 0, 0, "");
    for (int i = 0; i < 6; i++) tap(1'b0, 1'b0, 80, 80, 1'b0, 1'b0, 0, 0, "");
    tap(1'b0, 1'b1, 80, 80, 1'b0, 1'b1, 10, 10, "taps8");
    idle(3);

    // Restart mid-group: only the new group emerges; lanes carry different sums
    tap(1'b1, 1'b0, 1000, 1000, 1'b0, 1'b0, 0, 0, "");
    tap(1'b0, 1'b0, 1000, 1000, 1'b0, 1'b0, 0, 0, "");
    tap(1'b0, 1'b0, 1000, 1000, 1'b0, 1'b0, 0, 0, "");
    tap(1'b1, 1'b0, 320, 640, 1'b1, 1'b0, 0, 0, "");
    tap(1'b0, 1'b1, 320, 640, 1'b0, 1'b1, 10, 20, "restart");
    idle(3);

    // Restart with a single-tap group, then four back-to-back single taps
    tap(1'b1, 1'b0, 2000, 2000, 1'b0, 1'b0, 0, 0, "");
    tap(1'b1, 1'b1, 64, -64, 1'b1, 1'b1, 1, 0, "acc_first_last");
    tap(1'b1, 1'b1, 64, 64, 1'b0, 1'b1, 1, 1, "b2b_1");
    tap(1'b1, 1'b1, 128, 128, 1'b0, 1'b1, 2, 2, "b2b_2");
    tap(1'b1, 1'b1, 192, 192, 1'b0, 1'b1, 3, 3, "b2b_3");
    tap(1'b1, 1'b1, 256, 256, 1'b0, 1'b1, 4, 4, "b2b_4");
    idle(3);

    // Reset mid-group discards it and clears the held pixels
    tap(1'b1, 1'b0, 3200, 3200, 1'b0, 1'b0, 0, 0, "");
    tap(1'b0, 1'b0, 3200, 3200, 1'b0, 1'b0, 0, 0, "");
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_idle_outputs("midreset");
    tap(1'b1, 1'b0, 3200, 3200, 1'b0, 1'b0, 0, 0, "");
    tap(1'b0, 1'b1, 3200, 3200, 1'b0, 1'b1, 100, 100, "post_reset");
    idle(4);

    chk("pending_outputs", q_a.size(), 0);
    chk("pending_errors", q_err.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
